// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: write-clock-domain half of the async FIFO.
// Two requesters share the single memory write port. Arbitration is round-robin
// with a burst limit. The block owns the binary/Gray write pointer and derives
// FULL, AFULL and the fill level from the synchronised Gray read pointer.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int AFULL_LEVEL   = 12,
    parameter int BURST_LEN     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ0,
    input  logic [DATA_WIDTH-1:0]    DATA0,
    output logic                     GNT0,
    input  logic                     REQ1,
    input  logic [DATA_WIDTH-1:0]    DATA1,
    output logic                     GNT1,
    input  logic [ADDRESS_WIDTH:0]   Wq2_Rptr,
    output logic                     W_en,
    output logic [ADDRESS_WIDTH-1:0] W_addr,
    output logic [DATA_WIDTH-1:0]    W_data,
    output logic [ADDRESS_WIDTH:0]   W_ptr,
    output logic                     FULL,
    output logic                     AFULL,
    output logic [ADDRESS_WIDTH:0]   W_level
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int CW = $clog2(BURST_LEN + 1);

    // Burst counter only needs to reach BURST_LEN; it saturates there.
    localparam logic [CW-1:0] BURST_MAX = BURST_LEN[CW-1:0];
    localparam logic [AW:0]   AFULL_THR = AFULL_LEVEL[AW:0];

    // One-hot ownership: the value 1 means requester 0 holds the burst.
    typedef enum logic [1:0] {
        OWN_REQ0 = 2'b01,
        OWN_REQ1 = 2'b10
    } owner_t;

    owner_t          owner_q;
    owner_t          owner_next;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_next;

    logic            grant0;
    logic            grant1;
    logic            accept;
    logic [1:0]      grant_vec;

    logic [AW:0]     wbin_q;
    logic [AW:0]     wbin_next;
    logic [AW:0]     wgray_next;
    logic [AW:0]     rbin;
    logic [AW:0]     full_pattern;
    logic [AW:0]     level_next;
    logic            full_next;
    logic            afull_next;

    // Convert a Gray-coded pointer back to binary (prefix XOR from the MSB down).
    function automatic logic [AW:0] gray_to_bin(input logic [AW:0] gray);
        logic [AW:0] bin;
        bin[AW] = gray[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Arbitration state: current burst owner and how many grants it has had in a row.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner_q <= OWN_REQ0;
            count_q <= '0;
        end else begin
            owner_q <= owner_next;
            count_q <= count_next;
        end
    end

    // Grant selection and next owner/count; nothing is granted while FULL or in reset.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        owner_next = owner_q;
        count_next = count_q;

        if (RST && !FULL) begin
            if (REQ0 && REQ1) begin
                if (count_q < BURST_MAX) begin
                    grant0 = (owner_q == OWN_REQ0);
                    grant1 = (owner_q == OWN_REQ1);
                end else begin
                    grant0 = (owner_q == OWN_REQ1);
                    grant1 = (owner_q == OWN_REQ0);
                end
            end else begin
                grant0 = REQ0;
                grant1 = REQ1;
            end
        end

        accept    = grant0 | grant1;
        grant_vec = {grant1, grant0};

        if (accept) begin
            if (grant_vec != owner_q) begin
                owner_next = owner_t'(grant_vec);
                count_next = {{(CW-1){1'b0}}, 1'b1};
            end else if (count_q != BURST_MAX) begin
                count_next = count_q + 1'b1;
            end
        end
    end

    assign GNT0 = grant0;
    assign GNT1 = grant1;

    // Next pointer and status; a write and a read-pointer move in the same cycle both count here.
    always_comb begin
        wbin_next    = wbin_q + {{AW{1'b0}}, accept};
        wgray_next   = wbin_next ^ (wbin_next >> 1);
        rbin         = gray_to_bin(Wq2_Rptr);
        full_pattern = {~Wq2_Rptr[AW:AW-1], Wq2_Rptr[AW-2:0]};
        full_next    = (wgray_next == full_pattern);
        level_next   = wbin_next - rbin;
        afull_next   = (level_next >= AFULL_THR);
    end

    // Registered write port, pointers and flags; address/data hold when no word is written.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wbin_q  <= '0;
            W_en    <= 1'b0;
            W_addr  <= '0;
            W_data  <= '0;
            W_ptr   <= '0;
            FULL    <= 1'b0;
            AFULL   <= 1'b0;
            W_level <= '0;
        end else begin
            wbin_q  <= wbin_next;
            W_en    <= accept;
            if (accept) begin
                W_addr <= wbin_q[AW-1:0];
                W_data <= grant0 ? DATA0 : DATA1;
            end
            W_ptr   <= wgray_next;
            FULL    <= full_next;
            AFULL   <= afull_next;
            W_level <= level_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic, compared every
// cycle against a word-counting model of the FIFO write side.
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int BL    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ0 = 1'b0;
    logic [DW-1:0] DATA0 = '0;
    logic          GNT0;
    logic          REQ1 = 1'b0;
    logic [DW-1:0] DATA1 = '0;
    logic          GNT1;
    logic [AW:0]   Wq2_Rptr;
    logic          W_en;
    logic [AW-1:0] W_addr;
    logic [DW-1:0] W_data;
    logic [AW:0]   W_ptr;
    logic          FULL;
    logic          AFULL;
    logic [AW:0]   W_level;

    // Read side is represented by a plain count of words consumed.
    int            rd_count = 0;
    logic [AW:0]   rptr_bin;

    // Model: total words written, last winner and its run length, registered outputs.
    int            m_wr;
    int            m_level;
    int            m_last;
    int            m_run;
    bit            m_full;
    bit            m_afull;
    bit            m_wen;
    bit            m_g0;
    bit            m_g1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    int            n_checks = 0;
    int            n_fails  = 0;
    bit            track_reads = 1'b0;
    bit            random_mode = 1'b0;
    int            req_rate = 50;
    int            rd_rate  = 50;

    fifo_wr_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .AFULL_LEVEL  (AFL),
        .BURST_LEN    (BL)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ0    (REQ0),
        .DATA0   (DATA0),
        .GNT0    (GNT0),
        .REQ1    (REQ1),
        .DATA1   (DATA1),
        .GNT1    (GNT1),
        .Wq2_Rptr(Wq2_Rptr),
        .W_en    (W_en),
        .W_addr  (W_addr),
        .W_data  (W_data),
        .W_ptr   (W_ptr),
        .FULL    (FULL),
        .AFULL   (AFULL),
        .W_level (W_level)
    );

    // Free-running write clock, 10 time units per period.
    always #5 CLK = ~CLK;

    assign rptr_bin = rd_count[AW:0];
    assign Wq2_Rptr = rptr_bin ^ (rptr_bin >> 1);

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Who must be granted now: the sole requester, or the burst holder until it has had BL words.
    function automatic void model_grant(output bit g0, output bit g1);
        int winner;
        g0 = 1'b0;
        g1 = 1'b0;
        if (RST && !m_full) begin
            if (REQ0 && REQ1) begin
                winner = (m_run < BL) ? m_last : 1 - m_last;
                g0 = (winner == 0);
                g1 = (winner == 1);
            end else begin
                g0 = REQ0;
                g1 = REQ1;
            end
        end
    endfunction

    task automatic model_reset();
        m_wr = 0; m_level = 0; m_last = 0; m_run = 0;
        m_full = 0; m_afull = 0; m_wen = 0; m_g0 = 0; m_g1 = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic model_step();
        bit g0;
        bit g1;
        int w;
        model_grant(g0, g1);
        m_g0 = g0;
        m_g1 = g1;
        if (g0 || g1) begin
            w = g0 ? 0 : 1;
            m_wen  = 1;
            m_addr = AW'(m_wr % DEPTH);
            m_data = g0 ? DATA0 : DATA1;
            if (w == m_last) m_run++;
            else begin
                m_last = w;
                m_run  = 1;
            end
            m_wr++;
        end else begin
            m_wen = 0;
        end
        m_level = m_wr - rd_count;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= AFL);
    endtask

    // Model advances on every clock edge and is cleared by reset.
    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) model_reset();
            else model_step();
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge CLK) begin : compare_proc
        bit g0;
        bit g1;
        model_grant(g0, g1);
        checkOutput("GNT0", 32'(GNT0), 32'(g0));
        checkOutput("GNT1", 32'(GNT1), 32'(g1));
        checkOutput("W_en", 32'(W_en), 32'(m_wen));
        if (m_wen) begin
            checkOutput("W_addr", 32'(W_addr), 32'(m_addr));
            checkOutput("W_data", 32'(W_data), 32'(m_data));
        end
        checkOutput("W_ptr", 32'(W_ptr), 32'(to_gray(m_wr)));
        checkOutput("FULL", 32'(FULL), 32'(m_full));
        checkOutput("AFULL", 32'(AFULL), 32'(m_afull));
        checkOutput("W_level", 32'(W_level), 32'(m_level));
    end

    // Advance one clock, then drive the inputs for the next cycle.
    task automatic applyStimulus();
        @(posedge CLK);
        #1;
        if (m_g0) DATA0 = DW'($urandom);
        if (m_g1) DATA1 = DW'($urandom);
        if (random_mode) begin
            if (!REQ0 || m_g0) REQ0 = ($urandom_range(0, 99) < req_rate);
            if (!REQ1 || m_g1) REQ1 = ($urandom_range(0, 99) < req_rate);
            if (rd_count < m_wr && $urandom_range(0, 99) < rd_rate) rd_count++;
        end
        if (track_reads) rd_count = m_wr;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        rd_count = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin : main
        int grants;
        int afull_at;
        int full_at;
        int win;
        int cont_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int arr_seq[5]  = '{0, 0, 0, 0, 1};
        logic [AW:0] prev_ptr;
        bit saw_wrap;
        bit saw_full;

        DATA0 = DW'($urandom);
        DATA1 = DW'($urandom);
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset W_en", 32'(W_en), 32'd0);
        checkOutput("reset W_ptr", 32'(W_ptr), 32'd0);
        checkOutput("reset FULL", 32'(FULL), 32'd0);
        checkOutput("reset W_level", 32'(W_level), 32'd0);

        // Fill from empty with no reads: 16 grants, AFULL after the 12th, FULL after the 16th.
        RST  = 1'b1;
        REQ0 = 1'b1;
        grants = 0; afull_at = -1; full_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0) checkOutput("first grant after reset", 32'(GNT0), 32'd1);
            if (AFULL && afull_at < 0) afull_at = grants;
            if (FULL && full_at < 0) full_at = grants;
            if (GNT0) grants++;
            applyStimulus();
        end
        checkOutput("fill grants", 32'(grants), 32'd16);
        checkOutput("fill AFULL point", 32'(afull_at), 32'd12);
        checkOutput("fill FULL point", 32'(full_at), 32'd16);
        checkOutput("fill W_level", 32'(W_level), 32'd16);
        checkOutput("fill GNT0 blocked", 32'(GNT0), 32'd0);

        // Drain one word: FULL drops one cycle later, one more grant, then FULL again.
        rd_count = 1;
        @(negedge CLK);
        checkOutput("drain FULL before", 32'(FULL), 32'd1);
        applyStimulus();
        @(negedge CLK);
        checkOutput("drain FULL cleared", 32'(FULL), 32'd0);
        checkOutput("drain W_level", 32'(W_level), 32'd15);
        checkOutput("drain grant", 32'(GNT0), 32'd1);
        applyStimulus();
        @(negedge CLK);
        checkOutput("drain FULL again", 32'(FULL), 32'd1);
        checkOutput("drain GNT0 blocked", 32'(GNT0), 32'd0);

        // Both requesters held on an empty FIFO: bursts of four alternate.
        do_reset();
        track_reads = 1'b1;
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            win = GNT1 ? 1 : 0;
            checkOutput("contention one-hot", 32'(GNT0 ^ GNT1), 32'd1);
            checkOutput("contention winner", 32'(win), 32'(cont_seq[i]));
            applyStimulus();
        end

        // REQ1 alone is granted every cycle; REQ0 then takes over immediately.
        do_reset();
        REQ1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checkOutput("solo REQ1 grant", 32'(GNT1), 32'd1);
            applyStimulus();
        end
        REQ0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            win = GNT1 ? 1 : 0;
            checkOutput("REQ0 arrival winner", 32'(win), 32'(arr_seq[i]));
            applyStimulus();
        end

        // Forty-plus writes with reads tracking: Gray pointer wraps, never FULL.
        do_reset();
        REQ0 = 1'b1;
        REQ1 = 1'b0;
        prev_ptr = '0; saw_wrap = 1'b0; saw_full = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            if (prev_ptr == 5'b10000 && W_ptr == 5'b00000) saw_wrap = 1'b1;
            if (FULL) saw_full = 1'b1;
            prev_ptr = W_ptr;
            applyStimulus();
        end
        checkOutput("wrap seen", 32'(saw_wrap), 32'd1);
        checkOutput("wrap false FULL", 32'(saw_full), 32'd0);

        // Randomized traffic with varying request and read rates, reset in the middle.
        track_reads = 1'b0;
        random_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                req_rate = $urandom_range(20, 100);
                rd_rate  = $urandom_range(10, 95);
            end
            if (i == 1500) begin
                random_mode = 1'b0;
                #2;
                REQ0 = 1'b1;
                REQ1 = 1'b0;
                RST  = 1'b0;
                #1;
                checkOutput("midreset W_en", 32'(W_en), 32'd0);
                checkOutput("midreset W_addr", 32'(W_addr), 32'd0);
                checkOutput("midreset W_data", 32'(W_data), 32'd0);
                checkOutput("midreset W_ptr", 32'(W_ptr), 32'd0);
                checkOutput("midreset FULL", 32'(FULL), 32'd0);
                checkOutput("midreset AFULL", 32'(AFULL), 32'd0);
                checkOutput("midreset W_level", 32'(W_level), 32'd0);
                checkOutput("midreset GNT0", 32'(GNT0), 32'd0);
                rd_count = 0;
                repeat (2) @(posedge CLK);
                #1;
                RST = 1'b1;
                @(negedge CLK);
                checkOutput("post-reset GNT0", 32'(GNT0), 32'd1);
                checkOutput("post-reset GNT1", 32'(GNT1), 32'd0);
                random_mode = 1'b1;
            end
            applyStimulus();
        end
        random_mode = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        repeat (3) applyStimulus();
        @(negedge CLK);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
